// File: rtl/tetris_pkg.sv
// Shared encodings for the tetris frame scheduler: phases, actions and FSM states.
package tetris_pkg;

    localparam logic [1:0] PH_TRY    = 2'd0;
    localparam logic [1:0] PH_CHECK  = 2'd1;
    localparam logic [1:0] PH_COMMIT = 2'd2;
    localparam logic [1:0] PH_UPDATE = 2'd3;

    localparam logic [1:0] ACT_NONE   = 2'd0;
    localparam logic [1:0] ACT_LEFT   = 2'd1;
    localparam logic [1:0] ACT_RIGHT  = 2'd2;
    localparam logic [1:0] ACT_ROTATE = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_TRY    = 3'd1;
    localparam state_t ST_CHECK  = 3'd2;
    localparam state_t ST_COMMIT = 3'd3;
    localparam state_t ST_UPDATE = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

endpackage

// File: rtl/btn_conditioner.sv
// One raw button: two-flop synchroniser, held level and single-cycle rising-edge strobe.
module btn_conditioner (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_i,
    output logic held_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign held_o = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/tetris_step_scheduler.sv
// Frame sequencer in front of the game core: conditions buttons, runs gravity and
// auto-repeat, and steps TRY/CHECK/COMMIT/UPDATE with one arbitrated action per frame.
//   state  | meaning
//   IDLE   | waiting for a pending button or gravity tick
//   TRY    | phase 0, datapath attempts the move
//   CHECK  | phase 1, collision validation
//   COMMIT | phase 2, result written back
//   UPDATE | phase 3, display refresh
//   DONE   | frame_done pulse, back to IDLE
module tetris_step_scheduler
    import tetris_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 12500000,
    parameter int unsigned REPEAT_DIV = 4000000,
    parameter int unsigned CNT_W      = 25
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       right,
    input  logic       left,
    input  logic       rotating,
    input  logic [1:0] speed,
    input  logic       halt,
    output logic [1:0] phase,
    output logic       phase_valid,
    output logic [1:0] action,
    output logic       drop,
    output logic       frame_done
);

    localparam logic [CNT_W-1:0] RPT_MAX = CNT_W'(REPEAT_DIV - 1);

    // bit 0 left, bit 1 right, bit 2 rotate
    logic [2:0] btn_raw;
    logic [2:0] held;
    logic [2:0] rise;

    assign btn_raw = {rotating, right, left};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        btn_conditioner u_btn (
            .clk_i   (CLK),
            .rst_n_i (CLR),
            .btn_i   (btn_raw[i]),
            .held_o  (held[i]),
            .rise_o  (rise[i])
        );
    end

    logic [2:0]       held_prev_q;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [2:0]       rpt_fire;
    logic             one_held;

    assign one_held = (held == 3'b001) || (held == 3'b010) || (held == 3'b100);

    always_comb begin
        rpt_cnt_d = '0;
        rpt_fire  = 3'b000;
        if (one_held && (held == held_prev_q)) begin
            if (rpt_cnt_q == RPT_MAX) rpt_fire = held;
            else                      rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
    end

    logic [CNT_W-1:0] grav_cnt_q, grav_cnt_d;
    logic [CNT_W-1:0] grav_lim;
    logic             tick;

    assign grav_lim = CNT_W'((TICK_DIV >> speed) - 32'd1);
    // >= so that lowering the limit below the current count wraps immediately
    assign tick     = !halt && (grav_cnt_q >= grav_lim);

    always_comb begin
        grav_cnt_d = grav_cnt_q;
        if (!halt) grav_cnt_d = tick ? '0 : grav_cnt_q + 1'b1;
    end

    state_t     state_q, state_d;
    logic [2:0] pend_q, pend_d;
    logic       grav_due_q, grav_due_d;
    logic [1:0] action_q, action_d;
    logic       drop_q, drop_d;
    logic [2:0] clr_mask;
    logic [1:0] act_sel;
    logic       launch;

    assign launch = (state_q == ST_IDLE) && !halt && ((|pend_q) || grav_due_q);

    // Simultaneous left+right cancel each other; rotate may still win.
    always_comb begin
        clr_mask = 3'b000;
        act_sel  = ACT_NONE;
        if (pend_q[0] && pend_q[1]) begin
            clr_mask = 3'b011;
            if (pend_q[2]) begin
                clr_mask = 3'b111;
                act_sel  = ACT_ROTATE;
            end
        end else if (pend_q[2]) begin
            clr_mask = 3'b100;
            act_sel  = ACT_ROTATE;
        end else if (pend_q[0]) begin
            clr_mask = 3'b001;
            act_sel  = ACT_LEFT;
        end else if (pend_q[1]) begin
            clr_mask = 3'b010;
            act_sel  = ACT_RIGHT;
        end
    end

    always_comb begin
        pend_d     = 3'b000;
        grav_due_d = 1'b0;
        if (!halt) begin
            pend_d     = (pend_q & ~(launch ? clr_mask : 3'b000)) | rise | rpt_fire;
            grav_due_d = tick | (grav_due_q & ~launch);
        end
    end

    always_comb begin
        state_d  = ST_IDLE;
        action_d = action_q;
        drop_d   = drop_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d  = ST_TRY;
                    action_d = act_sel;
                    drop_d   = grav_due_q;
                end
            end
            ST_TRY:    state_d = ST_CHECK;
            ST_CHECK:  state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_UPDATE;
            ST_UPDATE: begin
                state_d  = ST_DONE;
                action_d = ACT_NONE;
                drop_d   = 1'b0;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q     <= ST_IDLE;
            held_prev_q <= 3'b000;
            rpt_cnt_q   <= '0;
            grav_cnt_q  <= '0;
            pend_q      <= 3'b000;
            grav_due_q  <= 1'b0;
            action_q    <= ACT_NONE;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_prev_q <= held;
            rpt_cnt_q   <= rpt_cnt_d;
            grav_cnt_q  <= grav_cnt_d;
            pend_q      <= pend_d;
            grav_due_q  <= grav_due_d;
            action_q    <= action_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        phase       = PH_TRY;
        phase_valid = 1'b0;
        case (state_q)
            ST_TRY:    begin phase = PH_TRY;    phase_valid = 1'b1; end
            ST_CHECK:  begin phase = PH_CHECK;  phase_valid = 1'b1; end
            ST_COMMIT: begin phase = PH_COMMIT; phase_valid = 1'b1; end
            ST_UPDATE: begin phase = PH_UPDATE; phase_valid = 1'b1; end
            default:   begin phase = PH_TRY;    phase_valid = 1'b0; end
        endcase
    end

    assign action     = action_q;
    assign drop       = drop_q;
    assign frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_tetris_step_scheduler.sv
// Directed bench for tetris_step_scheduler with TICK_DIV=16, REPEAT_DIV=8.
module tb_tetris_step_scheduler;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic       right = 1'b0;
    logic       left = 1'b0;
    logic       rotating = 1'b0;
    logic [1:0] speed = 2'd0;
    logic       halt = 1'b0;
    logic [1:0] phase;
    logic       phase_valid;
    logic [1:0] action;
    logic       drop;
    logic       frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_rpt   = 0;
    logic saw_drop;

    tetris_step_scheduler #(
        .TICK_DIV   (16),
        .REPEAT_DIV (8),
        .CNT_W      (25)
    ) dut (
        .CLK         (CLK),
        .CLR         (CLR),
        .right       (right),
        .left        (left),
        .rotating    (rotating),
        .speed       (speed),
        .halt        (halt),
        .phase       (phase),
        .phase_valid (phase_valid),
        .action      (action),
        .drop        (drop),
        .frame_done  (frame_done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        cyc++;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) step();
    endtask

    // cyc=k means "sampled at the negedge after the k-th posedge since reset release"
    task automatic do_reset();
        @(negedge CLK);
        CLR = 1'b0; left = 1'b0; right = 1'b0; rotating = 1'b0; halt = 1'b0;
        #1;
        check("rst_pv",   phase_valid, 0);
        check("rst_fd",   frame_done, 0);
        check("rst_act",  action, 0);
        check("rst_drop", drop, 0);
        check("rst_ph",   phase, 0);
        @(negedge CLK);
        CLR = 1'b1;
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // gravity only: frames at TRY cycles 17, 33
        do_reset();
        go_to(16); check("g_launch_pv", phase_valid, 0);
        go_to(17); check("g_try_pv", phase_valid, 1); check("g_try_ph", phase, 0);
                   check("g_try_drop", drop, 1);      check("g_try_act", action, 0);
        go_to(18); check("g_check_ph", phase, 1);
        go_to(19); check("g_commit_ph", phase, 2);
        go_to(20); check("g_update_ph", phase, 3); check("g_update_drop", drop, 1);
        go_to(21); check("g_done_fd", frame_done, 1); check("g_done_pv", phase_valid, 0);
                   check("g_done_drop", drop, 0);
        go_to(22); check("g_idle_fd", frame_done, 0);
        go_to(32); check("g_gap_pv", phase_valid, 0);
        go_to(33); check("g2_try_pv", phase_valid, 1); check("g2_try_drop", drop, 1);

        // single left pulse: TRY at 6, nothing until gravity at 17
        do_reset();
        go_to(2); left = 1'b1;
        step();   left = 1'b0;
        go_to(5); check("l_early_pv", phase_valid, 0);
        go_to(6); check("l_try_pv", phase_valid, 1); check("l_try_act", action, 1);
                  check("l_try_drop", drop, 0);
        go_to(9); check("l_upd_ph", phase, 3); check("l_upd_act", action, 1);
        go_to(10); check("l_done_fd", frame_done, 1); check("l_done_act", action, 0);
        go_to(12); check("l_once_pv", phase_valid, 0);
        go_to(17); check("l_grav_pv", phase_valid, 1); check("l_grav_act", action, 0);
                   check("l_grav_drop", drop, 1);

        // left + rotate together: rotate first, left next frame, then gravity
        do_reset();
        go_to(2); left = 1'b1; rotating = 1'b1;
        step();   left = 1'b0; rotating = 1'b0;
        go_to(6);  check("lr_rot_pv", phase_valid, 1); check("lr_rot_act", action, 3);
                   check("lr_rot_drop", drop, 0);
        go_to(12); check("lr_left_pv", phase_valid, 1); check("lr_left_ph", phase, 0);
                   check("lr_left_act", action, 1); check("lr_left_drop", drop, 0);
        go_to(18); check("lr_grav_pv", phase_valid, 1); check("lr_grav_act", action, 0);
                   check("lr_grav_drop", drop, 1);

        // left + right together: cancelled, only action 0 seen
        do_reset();
        saw_drop = 1'b0;
        go_to(2); left = 1'b1; right = 1'b1;
        step();   left = 1'b0; right = 1'b0;
        while (cyc < 30) begin
            step();
            check("lrc_act", action, 0);
            if (drop) saw_drop = 1'b1;
        end
        check("lrc_grav_seen", saw_drop, 1);

        // right held 40 cycles: right frames at TRY 6,14,26,32,38, gravity at 20,38,49
        do_reset();
        n_rpt = 0;
        go_to(2); right = 1'b1;
        while (cyc < 60) begin
            step();
            if (cyc == 42) right = 1'b0;
            if (phase_valid && phase == 2'd0 && action == 2'd2) n_rpt++;
            if (cyc == 6 || cyc == 14) begin
                check("rpt_try_pv", phase_valid, 1);
                check("rpt_try_act", action, 2);
            end
            if (cyc == 13) check("rpt_gap_pv", phase_valid, 0);
            if (cyc == 49) begin
                check("rpt_after_pv", phase_valid, 1);
                check("rpt_after_act", action, 0);
                check("rpt_after_drop", drop, 1);
            end
        end
        check("rpt_count", n_rpt, 5);

        // halt during CHECK of the first gravity frame; counter held at 2
        do_reset();
        go_to(18); halt = 1'b1;
        go_to(19); check("h_commit_ph", phase, 2); check("h_commit_pv", phase_valid, 1);
        go_to(20); check("h_update_ph", phase, 3);
        go_to(21); check("h_done_fd", frame_done, 1);
        while (cyc < 60) begin
            step();
            if (cyc == 30) left = 1'b1;
            if (cyc == 31) left = 1'b0;
            check("h_pv", phase_valid, 0);
            check("h_drop", drop, 0);
        end
        halt = 1'b0;
        go_to(74); check("h_resume_early", phase_valid, 0);
        go_to(75); check("h_resume_pv", phase_valid, 1); check("h_resume_drop", drop, 1);
                   check("h_resume_act", action, 0);

        // speed raised while count (10) is already past the new limit (3)
        do_reset();
        go_to(10); speed = 2'd2;
        go_to(11); check("sp_launch_pv", phase_valid, 0);
        go_to(12); check("sp_try_pv", phase_valid, 1); check("sp_try_drop", drop, 1);

        // speed 1: a tick landing in a button launch cycle is kept for the next frame
        speed = 2'd1;
        do_reset();
        go_to(9);  check("kt_g_pv", phase_valid, 1); check("kt_g_drop", drop, 1);
        go_to(12); left = 1'b1;
        step();    left = 1'b0;
        go_to(16); check("kt_l_pv", phase_valid, 1); check("kt_l_act", action, 1);
                   check("kt_l_drop", drop, 0);
        go_to(21); check("kt_gap_pv", phase_valid, 0);
        go_to(22); check("kt_g2_pv", phase_valid, 1); check("kt_g2_drop", drop, 1);
                   check("kt_g2_act", action, 0);

        // speed 2 and reset during COMMIT
        speed = 2'd2;
        do_reset();
        go_to(5); check("s2_try_pv", phase_valid, 1); check("s2_try_drop", drop, 1);
        go_to(7); check("s2_commit_ph", phase, 2);
        CLR = 1'b0;
        #1;
        check("ab_pv", phase_valid, 0);
        check("ab_drop", drop, 0);
        check("ab_fd", frame_done, 0);
        step();
        check("ab_fd_next", frame_done, 0);
        check("ab_pv_next", phase_valid, 0);
        CLR = 1'b1;
        cyc = 0;
        go_to(4); check("ab_restart_early", phase_valid, 0);
        go_to(5); check("ab_restart_pv", phase_valid, 1); check("ab_restart_drop", drop, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
